// File: rtl/addsub_share_arbiter_pkg.sv
// Shared definitions for the add/subtract sharing arbiter.
//   - Controller state encoding (legacy-compatible 2-bit constants)
//   - Operation select encoding
//   - Default datapath width
package addsub_share_arbiter_pkg;

  // Controller states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Operation select
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Default operand/sum width
  localparam int unsigned DEFAULT_WIDTH = 6;

endpackage

// File: rtl/addsub_core.sv
// Combinational two's-complement add/subtract datapath.
// Ports:
//   x, y      operands
//   sel       0 = add (x + y), 1 = subtract (x - y)
//   sum       result, WIDTH bits
//   cout      carry out of the MSB (for subtract, 1 = no borrow)
//   overflow  signed overflow
module addsub_core
  import addsub_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH:0]   carry;

  // Subtract is x + ~y + 1; the +1 enters as the carry-in of bit 0.
  assign y_eff = (sel == SUB) ? ~y : y;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = sel;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i]     = x[i] ^ y_eff[i] ^ carry[i];
      carry[i+1] = (x[i] & y_eff[i]) | (x[i] & carry[i]) | (y_eff[i] & carry[i]);
    end
  end

  assign cout     = carry[WIDTH];
  assign overflow = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/addsub_share_arbiter.sv
// Shares one add/subtract datapath between two valid/ready requesters with
// round-robin arbitration. Each accepted operation produces one registered,
// ID-tagged response.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req{0,1}_valid/_ready         request handshake (ready only in IDLE, to the grantee)
//   req{0,1}_x/_y/_sel            operands and op select (0 add, 1 subtract x - y)
//   rsp_valid/rsp_ready           response handshake
//   rsp_id                        requester that issued the result
//   rsp_sum/rsp_cout/rsp_overflow result, carry-out, signed overflow
//   busy                          controller not in IDLE
//   ops_done                      saturating count of completed responses
module addsub_share_arbiter
  import addsub_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q;
  logic [WIDTH-1:0] op_x_q, op_y_q;
  logic             op_sel_q, op_id_q;
  logic             rsp_valid_q, rsp_id_q, rsp_cout_q, rsp_overflow_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic [CNT_W-1:0] ops_done_q;

  logic             grant0, grant1, accept, grant_id;
  logic             rsp_fire;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout, core_overflow;

  // Round-robin: on contention the requester that did not win last time goes.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign grant_id   = grant1;
  assign rsp_fire   = (state_q == RESP) && rsp_valid_q && rsp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x        (op_x_q),
    .y        (op_y_q),
    .sel      (op_sel_q),
    .sum      (core_sum),
    .cout     (core_cout),
    .overflow (core_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_x_q       <= '0;
      op_y_q       <= '0;
      op_sel_q     <= ADD;
      op_id_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_x_q       <= grant_id ? req1_x   : req0_x;
        op_y_q       <= grant_id ? req1_y   : req0_y;
        op_sel_q     <= grant_id ? req1_sel : req0_sel;
        op_id_q      <= grant_id;
        last_grant_q <= grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_sum_q      <= '0;
      rsp_cout_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      ops_done_q     <= '0;
    end else begin
      if (state_q == EXEC) begin
        rsp_valid_q    <= 1'b1;
        rsp_id_q       <= op_id_q;
        rsp_sum_q      <= core_sum;
        rsp_cout_q     <= core_cout;
        rsp_overflow_q <= core_overflow;
      end else if (rsp_fire) begin
        // Data registers deliberately keep their last values.
        rsp_valid_q <= 1'b0;
        if (ops_done_q != {CNT_W{1'b1}}) begin
          ops_done_q <= ops_done_q + 1'b1;
        end
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_cout     = rsp_cout_q;
  assign rsp_overflow = rsp_overflow_q;
  assign busy         = (state_q != IDLE);
  assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
module tb_addsub_share_arbiter;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic             req0_sel = 1'b0, req1_sel = 1'b0;
  logic             rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, rsp_overflow, busy;
  logic [WIDTH-1:0] rsp_sum;
  logic [CNT_W-1:0] ops_done;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  addsub_share_arbiter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_x       (req0_x),
    .req0_y       (req0_y),
    .req0_sel     (req0_sel),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_x       (req1_x),
    .req1_y       (req1_y),
    .req1_sel     (req1_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow),
    .busy         (busy),
    .ops_done     (ops_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
  endtask

  // One op from a single requester; rsp_ready held high.
  task automatic do_op(input string tag, input bit id, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input bit sel,
                       input logic [WIDTH-1:0] es, input bit ec, input bit eo);
    int n;
    if (id) begin
      req1_x = x; req1_y = y; req1_sel = sel; req1_valid = 1'b1;
    end else begin
      req0_x = x; req0_y = y; req0_sel = sel; req0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    tick();  // accept edge
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    tick();  // EXEC edge
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_sum"}, 32'(rsp_sum), 32'(es));
    check({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
    check({tag, "_ovf"}, 32'(rsp_overflow), 32'(eo));
    tick();  // handshake edge
    exp_cnt++;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ops_done"}, 32'(ops_done), 32'(exp_cnt));
  endtask

  initial begin : main
    int     ids[$];
    int     r0, r1, n;
    logic [WIDTH-1:0] snap_sum;
    logic   snap_id, snap_c, snap_o;

    // Reset values
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_sum", 32'(rsp_sum), 32'd0);
    check("rst_cout", 32'(rsp_cout), 32'd0);
    check("rst_ovf", 32'(rsp_overflow), 32'd0);
    check("rst_ops", 32'(ops_done), 32'd0);
    check("rst_rdy0", 32'(req0_ready), 32'd0);
    do_reset();

    // Directed arithmetic vectors
    do_op("r0_add", 1'b0, 6'd5, 6'd3, 1'b0, 6'd8, 1'b0, 1'b0);
    do_op("r1_add_ovf", 1'b1, 6'd31, 6'd1, 1'b0, 6'b100000, 1'b0, 1'b1);
    do_op("r1_sub_neg", 1'b1, 6'd5, 6'd7, 1'b1, 6'b111110, 1'b0, 1'b0);
    do_op("r0_sub_ovf", 1'b0, 6'b100000, 6'd1, 1'b1, 6'd31, 1'b1, 1'b1);
    do_op("r1_sub_zero", 1'b1, 6'd9, 6'd9, 1'b1, 6'd0, 1'b1, 1'b0);

    // Round-robin with both requesters valid continuously after reset
    do_reset();
    req0_x = 6'd1; req0_y = 6'd2; req0_sel = 1'b0;
    req1_x = 6'd4; req1_y = 6'd4; req1_sel = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    r0 = 0; r1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (req0_ready) r0++;
      if (req1_ready) r1++;
      if (req0_ready && req1_ready) check("rr_both_ready", 32'd1, 32'd0);
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        check("rr_sum", 32'(rsp_sum), rsp_id ? 32'd8 : 32'd3);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_nresp", 32'(ids.size()), 32'd4);
    for (int i = 0; i < ids.size() && i < 4; i++) begin
      check($sformatf("rr_id%0d", i), 32'(ids[i]), 32'(i % 2));
    end
    check("rr_rdy0_pulses", 32'(r0), 32'd2);
    check("rr_rdy1_pulses", 32'(r1), 32'd2);
    exp_cnt += 4;
    tick();
    tick();
    check("rr_ops", 32'(ops_done), 32'(exp_cnt));

    // Backpressure: both still requesting while the response is stalled
    rsp_ready = 1'b0;
    req0_x = 6'd10; req0_y = 6'd20; req0_sel = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    check("bp_valid", 32'(rsp_valid), 32'd1);
    snap_sum = rsp_sum; snap_id = rsp_id; snap_c = rsp_cout; snap_o = rsp_overflow;
    check("bp_sum", 32'(rsp_sum), rsp_id ? 32'd8 : 32'd30);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", {rsp_sum, rsp_id, rsp_cout, rsp_overflow},
            {snap_sum, snap_id, snap_c, snap_o});
      check("bp_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      check("bp_ops", 32'(ops_done), 32'(exp_cnt));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    check("bp_release_ops", 32'(ops_done), 32'(exp_cnt));
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_keep_sum", 32'(rsp_sum), 32'(snap_sum));

    // Reset during EXEC after requester 0 wins; then 0 must win again
    req0_x = 6'd3; req0_y = 6'd3; req0_sel = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("rx_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("rx_busy_exec", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rx_busy", 32'(busy), 32'd0);
    check("rx_valid", 32'(rsp_valid), 32'd0);
    check("rx_ops", 32'(ops_done), 32'd0);
    tick();
    check("rx_no_replay", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rx_first_rdy0", 32'(req0_ready), 32'd1);
    check("rx_first_rdy1", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;

    // Saturation: keep requester 0 going past 255 completions
    n = 0;
    r0 = 0;
    while (r0 < 258 && n < 2000) begin
      if (rsp_valid && rsp_ready) r0++;
      if (r0 == 254 && rsp_valid && rsp_ready) check("sat_254", 32'(ops_done), 32'd253);
      tick();
      n++;
    end
    check("sat_handshakes", 32'(r0), 32'd258);
    req0_valid = 1'b0;
    tick();
    check("sat_ops", 32'(ops_done), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
